// File: rtl/scan_mvm_core_if.sv
// Scan port bundle for scan_mvm_core: two-phase shift clocks, serial data in/out,
// load strobes and the chain select. The master drives pins; the core is the slave.
interface scan_mvm_core_if;
    logic scan_id;
    logic scan_phi;
    logic scan_phi_bar;
    logic scan_data_in;
    logic scan_load_chip;
    logic scan_load_chain;
    logic scan_data_out;

    modport master (
        output scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain,
        input  scan_data_out
    );

    modport slave (
        input  scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain,
        output scan_data_out
    );
endinterface

// File: rtl/scan_mvm_core.sv
// Scan-programmable NxN signed matrix-vector multiplier. All configuration and
// readback go through a two-phase scan port sampled into the clk domain. A run
// computes one result row per cycle from operands captured at launch.
module scan_mvm_core #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(N),
    parameter int SYNC   = 2
) (
    input  logic           clk,
    input  logic           rst_n,   // active-high synchronous reset
    scan_mvm_core_if.slave scan
);
    localparam int W_BITS = N*N*DATA_W;
    localparam int X_BITS = N*DATA_W;
    localparam int CFG_L  = 1 + W_BITS + X_BITS;
    localparam int RES_L  = 2 + N*ACC_W;
    localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    // Pin order keeps the four edge-detected strobes in the low bits.
    logic [5:0]            pins;
    logic [5:0]            sync_q [SYNC];
    logic [5:0]            sync_o;
    logic [3:0]            prev_q;
    logic [3:0]            rise;
    logic                  phi_r, phb_r, lcp_r, lcn_r, id, din;

    logic [CFG_L-1:0]      cfg;
    logic [RES_L-1:0]      res;
    logic [W_BITS-1:0]     w_sh;
    logic [X_BITS-1:0]     x_sh;
    logic [N-1:0][N-1:0][DATA_W-1:0] w_run;
    logic [N-1:0][DATA_W-1:0]        x_run;
    logic [N-1:0][ACC_W-1:0]         y;
    logic [ROW_W-1:0]      row;
    logic                  done;
    logic                  busy;
    logic                  sdo;
    logic                  launch;
    logic                  last_row;
    state_t                state_q, state_d;

    logic signed [ACC_W-1:0] row_sum, wa, xa;

    assign pins = {scan.scan_data_in, scan.scan_id, scan.scan_load_chain,
                   scan.scan_load_chip, scan.scan_phi_bar, scan.scan_phi};

    // Synchronize every scan pin and keep the previous strobe levels for edge detection.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_o[3:0];
        end
    end

    assign sync_o = sync_q[SYNC-1];
    assign rise   = sync_o[3:0] & ~prev_q;
    assign phi_r  = rise[0];
    assign phb_r  = rise[1];
    assign lcp_r  = rise[2];
    assign lcn_r  = rise[3];
    assign id     = sync_o[4];
    assign din    = sync_o[5];

    assign busy     = (state_q == RUN);
    assign last_row = busy && (row == ROW_W'(N-1));

    // Run state register.
    always_ff @(posedge clk) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Launch on load_chip with start set while idle; return to idle after the last row.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: if (lcp_r && cfg[0]) begin
                state_d = RUN;
                launch  = 1'b1;
            end
            RUN:  if (last_row) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Dot product of the current row of launched weights with the launched vector.
    always_comb begin
        row_sum = '0;
        wa      = '0;
        xa      = '0;
        for (int c = 0; c < N; c++) begin
            wa      = ACC_W'($signed(w_run[row][c]));
            xa      = ACC_W'($signed(x_run[c]));
            row_sum = row_sum + wa * xa;
        end
    end

    // Scan chains, shadow registers, launch capture and per-row result writeback.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cfg   <= '0;
            res   <= '0;
            w_sh  <= '0;
            x_sh  <= '0;
            w_run <= '0;
            x_run <= '0;
            y     <= '0;
            row   <= '0;
            done  <= 1'b0;
            sdo   <= 1'b0;
        end else begin
            // A load strobe in the same cycle as a phi edge swallows the shift.
            if (lcn_r) begin
                if (id) res <= {y, busy, done};
                else    cfg <= {x_sh, w_sh, 1'b0};
            end else if (phi_r && !lcp_r) begin
                if (id) res <= {din, res[RES_L-1:1]};
                else    cfg <= {din, cfg[CFG_L-1:1]};
            end

            if (phb_r) sdo <= id ? res[0] : cfg[0];

            // Shadows always follow load_chip; start itself is never stored.
            if (lcp_r) begin
                w_sh <= cfg[W_BITS:1];
                x_sh <= cfg[CFG_L-1:W_BITS+1];
            end

            if (launch) begin
                w_run <= cfg[W_BITS:1];
                x_run <= cfg[CFG_L-1:W_BITS+1];
                row   <= '0;
                done  <= 1'b0;
            end else if (busy) begin
                y[row] <= row_sum;
                row    <= row + 1'b1;
                if (last_row) done <= 1'b1;
            end
        end
    end

    assign scan.scan_data_out = sdo;
endmodule

// File: tb/tb_scan_mvm_core.sv
// Bench for scan_mvm_core: drives the scan port like an external tester and
// checks readback against an arithmetic matrix-vector model.
module tb_scan_mvm_core;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int AW    = 18;
    localparam int CFG_L = 161;
    localparam int RES_L = 74;
    localparam int HOLD  = 4;
    localparam int PHI = 0, PHB = 1, LCP = 2, LCN = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    scan_mvm_core_if sif();

    scan_mvm_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (sif)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int which, input int hi, input int lo);
        case (which)
            PHI:     sif.scan_phi        = 1'b1;
            PHB:     sif.scan_phi_bar    = 1'b1;
            LCP:     sif.scan_load_chip  = 1'b1;
            default: sif.scan_load_chain = 1'b1;
        endcase
        cyc(hi);
        sif.scan_phi        = 1'b0;
        sif.scan_phi_bar    = 1'b0;
        sif.scan_load_chip  = 1'b0;
        sif.scan_load_chain = 1'b0;
        cyc(lo);
    endtask

    task automatic select_chain(input logic sel);
        sif.scan_id = sel;
        cyc(HOLD);
    endtask

    // Element 0 goes in first and ends up at chain bit 0.
    task automatic shift_in(input logic [CFG_L-1:0] v, input int len);
        for (int i = 0; i < len; i++) begin
            sif.scan_data_in = v[i];
            pulse(PHI, HOLD, HOLD);
        end
        sif.scan_data_in = 1'b0;
    endtask

    task automatic shift_out(input int len, output logic [CFG_L-1:0] v);
        v = '0;
        for (int i = 0; i < len; i++) begin
            pulse(PHB, HOLD, HOLD);
            v[i] = sif.scan_data_out;
            pulse(PHI, HOLD, HOLD);
        end
    endtask

    function automatic logic [CFG_L-1:0] build_cfg(input int w[N*N], input int x[N], input logic start);
        logic [CFG_L-1:0] v;
        v    = '0;
        v[0] = start;
        for (int i = 0; i < N*N; i++) v[1 + i*DW +: DW] = DW'(w[i]);
        for (int c = 0; c < N; c++)   v[1 + N*N*DW + c*DW +: DW] = DW'(x[c]);
        return v;
    endfunction

    function automatic logic [AW-1:0] model_y(input int w[N*N], input int x[N], input int r);
        int acc;
        acc = 0;
        for (int c = 0; c < N; c++) acc += w[r*N + c] * x[c];
        return AW'(acc);
    endfunction

    // Program operands with start=1, wait out the run, capture and read the result chain.
    task automatic launch_and_read(input int w[N*N], input int x[N], output logic [RES_L-1:0] got);
        logic [CFG_L-1:0] v;
        select_chain(1'b0);
        shift_in(build_cfg(w, x, 1'b1), CFG_L);
        pulse(LCP, HOLD, HOLD);
        cyc(10);
        select_chain(1'b1);
        pulse(LCN, HOLD, HOLD);
        shift_out(RES_L, v);
        got = v[RES_L-1:0];
    endtask

    task automatic test_reset();
        logic [CFG_L-1:0] v;
        rst_n = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        checks++;
        if (sif.scan_data_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_sdo got %b exp 0", sif.scan_data_out);
        end
        select_chain(1'b1);
        shift_out(RES_L, v);
        checks++;
        if (v[RES_L-1:0] !== '0) begin
            errors++;
            $display("FAIL reset_res got %h exp 0", v[RES_L-1:0]);
        end
        select_chain(1'b0);
        shift_out(CFG_L, v);
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_cfg got %h exp 0", v);
        end
    endtask

    task automatic test_loopback();
        logic [CFG_L-1:0] pat, got, exp_v;
        logic [7:0]       a5;
        logic [RES_L-1:0] res_got;
        a5 = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CFG_L; i++) pat[i] = (k == 0) ? a5[i % 8] : 1'($urandom);
            // First pass has start clear; the random pass launches, which must not persist in CFG.
            pat[0] = (k == 1);
            select_chain(1'b0);
            shift_in(pat, CFG_L);
            pulse(LCP, HOLD, HOLD);
            pulse(LCN, HOLD, HOLD);
            shift_out(CFG_L, got);
            exp_v    = pat;
            exp_v[0] = 1'b0;
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL loopback%0d got %h exp %h", k, got, exp_v);
            end
            if (k == 0) begin
                // No launch happened: result chain still reads all zero.
                select_chain(1'b1);
                pulse(LCN, HOLD, HOLD);
                shift_out(RES_L, got);
                res_got = got[RES_L-1:0];
                checks++;
                if (res_got !== '0) begin
                    errors++;
                    $display("FAIL loopback_nolaunch got %h exp 0", res_got);
                end
            end
        end
    endtask

    task automatic test_identity();
        int w[N*N];
        int x[N];
        logic [RES_L-1:0] got;
        for (int i = 0; i < N*N; i++) w[i] = (i / N == i % N) ? 1 : 0;
        for (int c = 0; c < N; c++)   x[c] = c + 1;
        launch_and_read(w, x, got);
        checks++;
        if (got[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL ident_flags got busy=%b done=%b exp busy=0 done=1", got[1], got[0]);
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got[2 + r*AW +: AW] !== AW'(r + 1)) begin
                errors++;
                $display("FAIL ident_y%0d got %h exp %h", r, got[2 + r*AW +: AW], AW'(r + 1));
            end
        end
    endtask

    task automatic test_extremes();
        int w[N*N];
        int x[N];
        logic [RES_L-1:0] got;
        logic [AW-1:0]    exp_c;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N*N; i++) w[i] = (k == 0) ? -128 : 127;
            for (int c = 0; c < N; c++)   x[c] = -128;
            exp_c = (k == 0) ? 18'h10000 : 18'h30200;
            launch_and_read(w, x, got);
            checks++;
            if (got[1:0] !== 2'b01) begin
                errors++;
                $display("FAIL extreme%0d_flags got %b exp 01", k, got[1:0]);
            end
            for (int r = 0; r < N; r++) begin
                checks++;
                if (got[2 + r*AW +: AW] !== exp_c || model_y(w, x, r) !== exp_c) begin
                    errors++;
                    $display("FAIL extreme%0d_y%0d got %h exp %h", k, r, got[2 + r*AW +: AW], exp_c);
                end
            end
        end
    endtask

    task automatic test_random();
        int w[N*N];
        int x[N];
        logic [RES_L-1:0] got;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N*N; i++) w[i] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < N; c++)   x[c] = int'($urandom_range(0, 255)) - 128;
            launch_and_read(w, x, got);
            checks++;
            if (got[1:0] !== 2'b01) begin
                errors++;
                $display("FAIL rand%0d_flags got %b exp 01", k, got[1:0]);
            end
            for (int r = 0; r < N; r++) begin
                checks++;
                if (got[2 + r*AW +: AW] !== model_y(w, x, r)) begin
                    errors++;
                    $display("FAIL rand%0d_y%0d got %h exp %h", k, r, got[2 + r*AW +: AW], model_y(w, x, r));
                end
            end
        end
    endtask

    // Two quick load_chip strobes: the second lands while busy and must not relaunch.
    task automatic test_busy_relaunch();
        int w[N*N];
        int x[N];
        logic [CFG_L-1:0] v;
        logic [RES_L-1:0] got;
        int   busy_cnt, done_rises;
        logic prev_done;
        for (int i = 0; i < N*N; i++) w[i] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < N; c++)   x[c] = int'($urandom_range(0, 255)) - 128;
        select_chain(1'b0);
        shift_in(build_cfg(w, x, 1'b1), CFG_L);
        busy_cnt   = 0;
        done_rises = 0;
        prev_done  = dut.done;
        for (int k = 0; k < 30; k++) begin
            sif.scan_load_chip = (k == 0 || k == 2);
            cyc(1);
            if (dut.busy === 1'b1) busy_cnt++;
            if (dut.done === 1'b1 && prev_done !== 1'b1) done_rises++;
            prev_done = dut.done;
        end
        checks++;
        if (busy_cnt != N) begin
            errors++;
            $display("FAIL busy_cycles got %0d exp %0d", busy_cnt, N);
        end
        checks++;
        if (done_rises != 1) begin
            errors++;
            $display("FAIL done_once got %0d exp 1", done_rises);
        end
        select_chain(1'b1);
        pulse(LCN, HOLD, HOLD);
        shift_out(RES_L, v);
        got = v[RES_L-1:0];
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got[2 + r*AW +: AW] !== model_y(w, x, r)) begin
                errors++;
                $display("FAIL busy_y%0d got %h exp %h", r, got[2 + r*AW +: AW], model_y(w, x, r));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int w[N*N];
        int x[N];
        int t;
        logic [CFG_L-1:0] v;
        for (int i = 0; i < N*N; i++) w[i] = int'($urandom_range(1, 127));
        for (int c = 0; c < N; c++)   x[c] = int'($urandom_range(1, 127));
        select_chain(1'b0);
        shift_in(build_cfg(w, x, 1'b1), CFG_L);
        sif.scan_load_chip = 1'b1;
        t = 0;
        while (dut.busy !== 1'b1 && t < 20) begin
            cyc(1);
            t++;
        end
        sif.scan_load_chip = 1'b0;
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL midrun_launch got busy=%b exp 1 within 20 cycles", dut.busy);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        rst_n = 1'b0;
        checks++;
        if (dut.busy !== 1'b0 || dut.done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_flags got busy=%b done=%b exp 0 0", dut.busy, dut.done);
        end
        cyc(10);
        select_chain(1'b1);
        pulse(LCN, HOLD, HOLD);
        shift_out(RES_L, v);
        checks++;
        if (v[RES_L-1:0] !== '0) begin
            errors++;
            $display("FAIL midrun_res got %h exp 0", v[RES_L-1:0]);
        end
    endtask

    initial begin
        rst_n               = 1'b1;
        sif.scan_id         = 1'b0;
        sif.scan_phi        = 1'b0;
        sif.scan_phi_bar    = 1'b0;
        sif.scan_data_in    = 1'b0;
        sif.scan_load_chip  = 1'b0;
        sif.scan_load_chain = 1'b0;
        test_reset();
        test_loopback();
        test_identity();
        test_extremes();
        test_random();
        test_busy_relaunch();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
